// File: rtl/ctrl_fsm_param_pkg.sv
// ctrl_pkg: opcode and state encodings plus opcode classification helpers
// for the parametrised multi-cycle register-file controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_MVI = 4'd0,
    OP_MV  = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_NOT = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7
  } opcode_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  // Callers zero-extend func to 32 bits so one helper serves any FUNC_W.
  function automatic logic is_legal(input logic [31:0] f);
    return f < 32'd8;
  endfunction

  // Two-operand ALU ops: A is loaded from Rx before the ALU step.
  function automatic logic is_binary(input logic [31:0] f);
    return (f == 32'(OP_ADD)) || (f == 32'(OP_SUB)) || (f == 32'(OP_AND)) ||
           (f == 32'(OP_OR))  || (f == 32'(OP_XOR));
  endfunction

endpackage

// File: rtl/ctrl_fsm_param_if.sv
// Instruction-in / datapath-control-out bundle of ctrl_fsm_param.
// The stall input exists only when CTRL_STALL_EN is defined.
// extern_o carries the external-data (DIN) bus enable; "extern" is reserved.
interface ctrl_fsm_param_if #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned FUNC_W   = 4
);
  localparam int unsigned REG_SEL_W = $clog2(NUM_REGS);

  logic                 run;
  logic [FUNC_W-1:0]    func;
  logic [REG_SEL_W-1:0] Rx;
  logic [REG_SEL_W-1:0] Ry;
`ifdef CTRL_STALL_EN
  logic                 stall;
`endif
  logic [NUM_REGS-1:0]  R_in;
  logic [NUM_REGS-1:0]  R_out;
  logic                 A_in;
  logic                 G_in;
  logic                 G_out;
  logic                 extern_o;
  logic [FUNC_W-1:0]    alu_func;
  logic                 done;
  logic                 busy;
  logic                 illegal;

  // Instruction source / datapath side.
  modport master (
`ifdef CTRL_STALL_EN
    output stall,
`endif
    output run, func, Rx, Ry,
    input  R_in, R_out, A_in, G_in, G_out, extern_o, alu_func, done, busy, illegal
  );

  // Controller side.
  modport slave (
`ifdef CTRL_STALL_EN
    input  stall,
`endif
    input  run, func, Rx, Ry,
    output R_in, R_out, A_in, G_in, G_out, extern_o, alu_func, done, busy, illegal
  );
endinterface

// File: rtl/ctrl_fsm_param_reg_sel_decoder.sv
// reg_sel_decoder: register index + enable -> one-hot select.
// Output is all-zero when disabled or when the index is past NUM_REGS.
module reg_sel_decoder #(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                        en_i,
  input  logic [$clog2(NUM_REGS)-1:0] idx_i,
  output logic [NUM_REGS-1:0]         onehot_o
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  // Compare the index against every valid register number.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      onehot_o[i] = en_i && (idx_i == IDX_W'(i));
    end
  end
endmodule

// File: rtl/ctrl_fsm_param.sv
// ctrl_fsm_param: multi-cycle controller for the register-file processor.
// Latches (func, Rx, Ry) on run in T0 and sequences T1..T3; control outputs
// are decoded combinationally from the registered state and instruction.
// Optional feature: define CTRL_STALL_EN to add a stall input that holds
// the current step and blanks every output except busy.
module ctrl_fsm_param
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned FUNC_W   = 4
) (
  input  logic           clk,
  input  logic           reset,
  ctrl_fsm_param_if.slave bus
);
  localparam int unsigned REG_SEL_W = $clog2(NUM_REGS);

  state_e               state_q;
  logic [FUNC_W-1:0]    func_q;
  logic [REG_SEL_W-1:0] rx_q;
  logic [REG_SEL_W-1:0] ry_q;

  logic                 stall_c;
  logic                 legal_c;
  logic                 unary_c;
  logic                 binary_c;
  opcode_e              op_c;

  logic                 rin_en_c;
  logic                 rout_en_c;
  logic [REG_SEL_W-1:0] rout_idx_c;
  logic                 a_in_c;
  logic                 g_in_c;
  logic                 g_out_c;
  logic                 ext_c;
  logic                 done_c;
  logic                 illegal_c;

`ifdef CTRL_STALL_EN
  assign stall_c = bus.stall && (state_q != T0);
`else
  assign stall_c = 1'b0;
`endif

  // Instruction classification from the latched IR.
  assign legal_c  = is_legal(32'(func_q)) && (32'(rx_q) < NUM_REGS) && (32'(ry_q) < NUM_REGS);
  assign op_c     = opcode_e'(func_q[3:0]);
  assign unary_c  = legal_c && (op_c == OP_NOT);
  assign binary_c = legal_c && is_binary(32'(func_q));

  // State sequencing and instruction latch; run is only looked at in T0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= T0;
      func_q  <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
    end else begin
      case (state_q)
        T0: if (bus.run) begin
          state_q <= T1;
          func_q  <= bus.func;
          rx_q    <= bus.Rx;
          ry_q    <= bus.Ry;
        end
        T1: if (!stall_c) state_q <= (unary_c || binary_c) ? T2 : T0;
        T2: if (!stall_c) state_q <= unary_c ? T0 : T3;
        T3: if (!stall_c) state_q <= T0;
        default: state_q <= T0;
      endcase
    end
  end

  // Per-step datapath enables; a stalled step is a bubble.
  always_comb begin
    rin_en_c   = 1'b0;
    rout_en_c  = 1'b0;
    rout_idx_c = ry_q;
    a_in_c     = 1'b0;
    g_in_c     = 1'b0;
    g_out_c    = 1'b0;
    ext_c      = 1'b0;
    done_c     = 1'b0;
    illegal_c  = 1'b0;
    if (!stall_c) begin
      case (state_q)
        T1: begin
          if (!legal_c) begin
            done_c    = 1'b1;
            illegal_c = 1'b1;
          end else if (op_c == OP_MVI) begin
            ext_c    = 1'b1;
            rin_en_c = 1'b1;
            done_c   = 1'b1;
          end else if (op_c == OP_MV) begin
            rout_en_c = 1'b1;
            rin_en_c  = 1'b1;
            done_c    = 1'b1;
          end else if (unary_c) begin
            rout_en_c = 1'b1;
            g_in_c    = 1'b1;
          end else if (binary_c) begin
            rout_en_c  = 1'b1;
            rout_idx_c = rx_q;
            a_in_c     = 1'b1;
          end
        end
        T2: begin
          if (unary_c) begin
            g_out_c  = 1'b1;
            rin_en_c = 1'b1;
            done_c   = 1'b1;
          end else begin
            rout_en_c = 1'b1;
            g_in_c    = 1'b1;
          end
        end
        T3: begin
          g_out_c  = 1'b1;
          rin_en_c = 1'b1;
          done_c   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Destination register is always Rx.
  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .en_i     (rin_en_c),
    .idx_i    (rx_q),
    .onehot_o (bus.R_in)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .en_i     (rout_en_c),
    .idx_i    (rout_idx_c),
    .onehot_o (bus.R_out)
  );

  assign bus.A_in     = a_in_c;
  assign bus.G_in     = g_in_c;
  assign bus.G_out    = g_out_c;
  assign bus.extern_o = ext_c;
  assign bus.alu_func = g_in_c ? func_q : '0;
  assign bus.done     = done_c;
  assign bus.illegal  = illegal_c;
  assign bus.busy     = (state_q != T0);
endmodule

// File: tb/tb_ctrl_fsm_param.sv
// Bench for ctrl_fsm_param: an 8-register and a 6-register instance share
// identical stimulus; a queue of expected per-step outputs, expanded from
// each accepted instruction, serves as the reference.
module tb_ctrl_fsm_param;

  typedef struct packed {
    logic [7:0] rin;
    logic [7:0] rout;
    logic       a_in;
    logic       g_in;
    logic       g_out;
    logic       ext;
    logic [3:0] alu;
    logic       done;
    logic       illegal;
    logic       busy;
  } obs_t;

`ifdef CTRL_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run_v = 1'b0;
  logic [3:0] func_v = '0;
  logic [2:0] rx_v = '0;
  logic [2:0] ry_v = '0;
  logic       stall_v = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  obs_t q8[$];
  obs_t q6[$];

  always #5 clk = ~clk;

  ctrl_fsm_param_if #(.NUM_REGS(8), .FUNC_W(4)) bus8 ();
  ctrl_fsm_param_if #(.NUM_REGS(6), .FUNC_W(4)) bus6 ();

  ctrl_fsm_param #(.NUM_REGS(8), .FUNC_W(4)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  ctrl_fsm_param #(.NUM_REGS(6), .FUNC_W(4)) dut6 (.clk(clk), .reset(reset), .bus(bus6));

  // Number of cycles an accepted instruction occupies.
  function automatic int n_steps(input int nregs, input logic [3:0] f, input int rx, input int ry);
    if (f >= 4'd8 || rx >= nregs || ry >= nregs) return 1;
    if (f <= 4'd1) return 1;
    if (f == 4'd4) return 2;
    return 3;
  endfunction

  // Expected outputs for step k of an instruction, straight from the op table.
  function automatic obs_t make_step(input int nregs, input logic [3:0] f, input int rx,
                                     input int ry, input int k);
    obs_t s;
    logic [7:0] drx;
    logic [7:0] dry;
    s    = '0;
    drx  = 8'd1 << rx;
    dry  = 8'd1 << ry;
    s.busy = 1'b1;
    if (f >= 4'd8 || rx >= nregs || ry >= nregs) begin
      s.done = 1'b1; s.illegal = 1'b1;
    end else if (f == 4'd0) begin
      s.ext = 1'b1; s.rin = drx; s.done = 1'b1;
    end else if (f == 4'd1) begin
      s.rout = dry; s.rin = drx; s.done = 1'b1;
    end else if (f == 4'd4) begin
      if (k == 0) begin s.rout = dry; s.g_in = 1'b1; s.alu = f; end
      else begin s.g_out = 1'b1; s.rin = drx; s.done = 1'b1; end
    end else begin
      if (k == 0) begin s.rout = drx; s.a_in = 1'b1; end
      else if (k == 1) begin s.rout = dry; s.g_in = 1'b1; s.alu = f; end
      else begin s.g_out = 1'b1; s.rin = drx; s.done = 1'b1; end
    end
    return s;
  endfunction

  function automatic obs_t sample8();
    obs_t o;
    o = '{rin: bus8.R_in, rout: bus8.R_out, a_in: bus8.A_in, g_in: bus8.G_in,
          g_out: bus8.G_out, ext: bus8.extern_o, alu: bus8.alu_func, done: bus8.done,
          illegal: bus8.illegal, busy: bus8.busy};
    return o;
  endfunction

  function automatic obs_t sample6();
    obs_t o;
    o = '{rin: {2'b00, bus6.R_in}, rout: {2'b00, bus6.R_out}, a_in: bus6.A_in,
          g_in: bus6.G_in, g_out: bus6.G_out, ext: bus6.extern_o, alu: bus6.alu_func,
          done: bus6.done, illegal: bus6.illegal, busy: bus6.busy};
    return o;
  endfunction

  function automatic obs_t expect_now(input int qsize, input obs_t head);
    obs_t e;
    e = '0;
    if (qsize != 0) begin
      if (stall_v) e.busy = 1'b1;
      else e = head;
    end
    return e;
  endfunction

  task automatic check(input string tag);
    obs_t o8, e8, o6, e6;
    o8 = sample8();
    o6 = sample6();
    e8 = expect_now(q8.size(), (q8.size() != 0) ? q8[0] : obs_t'('0));
    e6 = expect_now(q6.size(), (q6.size() != 0) ? q6[0] : obs_t'('0));
    n_cmp++;
    assert (o8 === e8) else begin
      n_fail++;
      $error("FAIL %s regs8 observed=%h expected=%h", tag, o8, e8);
    end
    n_cmp++;
    assert (o6 === e6) else begin
      n_fail++;
      $error("FAIL %s regs6 observed=%h expected=%h", tag, o6, e6);
    end
  endtask

  // Reference update at the clock edge using the inputs held during the cycle.
  task automatic model_edge();
    if (reset) begin
      q8.delete();
      q6.delete();
    end else begin
      if (q8.size() != 0) begin
        if (!stall_v) void'(q8.pop_front());
      end else if (run_v) begin
        for (int k = 0; k < n_steps(8, func_v, int'(rx_v), int'(ry_v)); k++)
          q8.push_back(make_step(8, func_v, int'(rx_v), int'(ry_v), k));
      end
      if (q6.size() != 0) begin
        if (!stall_v) void'(q6.pop_front());
      end else if (run_v) begin
        for (int k = 0; k < n_steps(6, func_v, int'(rx_v), int'(ry_v)); k++)
          q6.push_back(make_step(6, func_v, int'(rx_v), int'(ry_v), k));
      end
    end
  endtask

  // One clock cycle: drive, check outputs mid-cycle, clock, advance model.
  task automatic cyc(input string tag, input logic rst, input logic r, input logic [3:0] f,
                     input logic [2:0] x, input logic [2:0] y, input logic st);
    reset   = rst;
    run_v   = r;
    func_v  = f;
    rx_v    = x;
    ry_v    = y;
    stall_v = st & STALL_EN;
    bus8.run = r; bus8.func = f; bus8.Rx = x; bus8.Ry = y;
    bus6.run = r; bus6.func = f; bus6.Rx = x; bus6.Ry = y;
`ifdef CTRL_STALL_EN
    bus8.stall = stall_v;
    bus6.stall = stall_v;
`endif
    #1;
    check(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    bus8.run = 1'b0; bus8.func = '0; bus8.Rx = '0; bus8.Ry = '0;
    bus6.run = 1'b0; bus6.func = '0; bus6.Rx = '0; bus6.Ry = '0;
`ifdef CTRL_STALL_EN
    bus8.stall = 1'b0;
    bus6.stall = 1'b0;
`endif
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state
    cyc("reset", 1'b1, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    cyc("reset_rel", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);

    // MVI R3
    cyc("mvi_acc", 1'b0, 1'b1, 4'h0, 3'd3, 3'd0, 1'b0);
    cyc("mvi_t1", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    cyc("mvi_idle", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);

    // ADD R1,R2 with IR inputs scrambled after accept
    cyc("add_acc", 1'b0, 1'b1, 4'h2, 3'd1, 3'd2, 1'b0);
    cyc("add_t1", 1'b0, 1'b0, 4'hF, 3'd7, 3'd7, 1'b0);
    cyc("add_t2", 1'b0, 1'b0, 4'hF, 3'd7, 3'd7, 1'b0);
    cyc("add_t3", 1'b0, 1'b0, 4'hF, 3'd7, 3'd7, 1'b0);
    cyc("add_idle", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);

    // NOT R5,R5 with run held high
    for (int i = 0; i < 7; i++) cyc("not_run", 1'b0, 1'b1, 4'h4, 3'd5, 3'd5, 1'b0);
    cyc("not_idle", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);

    // MV R7 (illegal only on the 6-register instance), then opcode 1010
    cyc("mv7_acc", 1'b0, 1'b1, 4'h1, 3'd7, 3'd1, 1'b0);
    cyc("mv7_t1", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    cyc("op10_acc", 1'b0, 1'b1, 4'hA, 3'd1, 3'd1, 1'b0);
    cyc("op10_t1", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    cyc("op10_idle", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);

    // SUB R3,R4 aborted by reset in T2
    cyc("sub_acc", 1'b0, 1'b1, 4'h3, 3'd3, 3'd4, 1'b0);
    cyc("sub_t1", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    cyc("sub_t2_rst", 1'b1, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    cyc("sub_abort", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    cyc("sub_idle", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);

    // XOR R2,R6 with a two-cycle stall in T2
    cyc("xor_acc", 1'b0, 1'b1, 4'h7, 3'd2, 3'd6, 1'b0);
    cyc("xor_t1", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    cyc("xor_stall", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b1);
    cyc("xor_stall", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b1);
    cyc("xor_t2", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    cyc("xor_t3", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);
    cyc("xor_idle", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);

    // Stall in T0 is ignored; AND R4,R4 reads the same register twice
    cyc("and_acc_st", 1'b0, 1'b1, 4'h5, 3'd4, 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) cyc("and_seq", 1'b0, 1'b0, 4'h0, 3'd0, 3'd0, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] f;
      f = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      cyc("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), f,
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
